// File: rtl/seg_display_pkg.sv
// Shared constants, state type and helpers for the BCD display path.
// Leading-zero blanking helper is used when BCD_LEADING_ZERO_BLANK_EN is set.
package seg_display_pkg;

  localparam int         BCD_DIGITS    = 4;
  localparam logic [3:0] BCD_BLANK     = 4'hF;
  localparam int         BCD_MAX_VALUE = 9999;

  typedef enum logic {
    IDLE,
    CONVERT
  } bcd_state_t;

  // Blank zero digits from the top down, stopping at the first non-zero one.
  function automatic logic [15:0] blank_leading(input logic [15:0] d);
    logic [15:0] r;
    logic        lead;
    r    = d;
    lead = 1'b1;
    for (int i = BCD_DIGITS - 1; i >= 1; i--) begin
      if (lead && d[i*4 +: 4] == 4'h0)
        r[i*4 +: 4] = BCD_BLANK;
      else
        lead = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to a BCD nibble that is 5 or more.
// Purely combinational.
module bcd_digit_adjust (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/binary_to_bcd_x_4.sv
// Sequential double-dabble binary to 4-digit packed BCD converter.
// Optional build macro: BCD_LEADING_ZERO_BLANK_EN (blank leading zeros).
module binary_to_bcd_x_4
  import seg_display_pkg::*;
#(
  parameter int IN_WIDTH = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IN_WIDTH-1:0] bin_in,
  input  logic [3:0]          dp_in,
  input  logic                valid_in,
  output logic                ready,
  output logic [15:0]         bcd_out,
  output logic [3:0]          dp_out,
  output logic                overflow,
  output logic                done
);

  localparam int SW = 16 + IN_WIDTH;
  localparam logic [4:0] LAST = 5'(IN_WIDTH - 1);

  bcd_state_t    state;
  logic [SW-1:0] sr;
  logic [4:0]    cnt;
  logic          ovf_q;
  logic [3:0]    dp_q;

  logic [15:0]   adj_bcd;
  logic [SW-1:0] adj_sr;
  logic [SW-1:0] nxt;
  logic [15:0]   res;
  logic [15:0]   fin;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d (sr[IN_WIDTH + 4*g +: 4]),
      .q (adj_bcd[4*g +: 4])
    );
  end

  assign adj_sr = {adj_bcd, sr[IN_WIDTH-1:0]};

  // Rotate rather than shift: the wrapped top bit is always zero for
  // representable results and never reaches the BCD field anyway.
  assign nxt = {adj_sr[SW-2:0], adj_sr[SW-1]};
  assign res = nxt[SW-1:IN_WIDTH];

`ifdef BCD_LEADING_ZERO_BLANK_EN
  assign fin = ovf_q ? 16'hFFFF : blank_leading(res);
`else
  assign fin = ovf_q ? 16'hFFFF : res;
`endif

  // Control FSM, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      ovf_q    <= 1'b0;
      dp_q     <= 4'b0000;
      ready    <= 1'b1;
      bcd_out  <= 16'hFFFF;
      dp_out   <= 4'b0000;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (valid_in) begin
            sr    <= {16'h0000, bin_in};
            dp_q  <= dp_in;
            ovf_q <= 32'(bin_in) > 32'(BCD_MAX_VALUE);
            cnt   <= '0;
            ready <= 1'b0;
            state <= CONVERT;
          end
        end
        CONVERT: begin
          sr  <= nxt;
          cnt <= cnt + 5'd1;
          if (cnt == LAST) begin
            bcd_out  <= fin;
            dp_out   <= dp_q;
            overflow <= ovf_q;
            done     <= 1'b1;
            ready    <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_to_bcd_x_4.sv
// Scoreboard bench for binary_to_bcd_x_4 with a decimal reference model.
// Honours BCD_LEADING_ZERO_BLANK_EN the same way the design build does.
module tb_binary_to_bcd_x_4;

  localparam int W = 14;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] bin_in;
  logic [3:0]   dp_in;
  logic         valid_in;
  logic         ready;
  logic [15:0]  bcd_out;
  logic [3:0]   dp_out;
  logic         overflow;
  logic         done;

  binary_to_bcd_x_4 #(.IN_WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bin_in   (bin_in),
    .dp_in    (dp_in),
    .valid_in (valid_in),
    .ready    (ready),
    .bcd_out  (bcd_out),
    .dp_out   (dp_out),
    .overflow (overflow),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [15:0] model_bcd(input int v);
    logic [15:0] r;
    if (v > 9999) return 16'hFFFF;
    r = 16'(((v / 1000) % 10) << 12) | 16'(((v / 100) % 10) << 8)
      | 16'(((v / 10) % 10) << 4) | 16'(v % 10);
`ifdef BCD_LEADING_ZERO_BLANK_EN
    if (v < 1000) r[15:12] = 4'hF;
    if (v < 100)  r[11:8]  = 4'hF;
    if (v < 10)   r[7:4]   = 4'hF;
`endif
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("bcd_out", 32'(bcd_out), 32'(e.bcd));
        chk("dp_out", 32'(dp_out), 32'(e.dp));
        chk("overflow", 32'(overflow), 32'(e.ovf));
        chk("latency", 32'(cyc - e.cyc), 32'(W));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the presenting edge.
  task automatic issue(input int v, input logic [3:0] dp);
    exp_t e;
    bin_in   = W'(v);
    dp_in    = dp;
    valid_in = 1'b1;
    if (ready && !reset) begin
      e.bcd = model_bcd(v);
      e.dp  = dp;
      e.ovf = v > 9999;
      e.cyc = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk);
    #1 valid_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (q.size() != 0) begin
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  initial begin
    logic [15:0] prev;
    int          n;
    reset    = 1'b1;
    valid_in = 1'b0;
    bin_in   = '0;
    dp_in    = 4'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'hFFFF);
    chk("rst_dp", 32'(dp_out), 32'd0);

    issue(1234, 4'b0100);
    drain();
    issue(9999, 4'b0001);
    drain();
    issue(10000, 4'b1000);
    drain();
    issue(16383, 4'b0010);
    drain();
    issue(42, 4'b0000);
    drain();
    issue(0, 4'b1111);
    drain();

    issue(1234, 4'b0101);
    n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_seen", 32'(done), 32'd1);
    chk("b2b_ready", 32'(ready), 32'd1);
    issue(7, 4'b0011);
    drain();

    issue(2468, 4'b1001);
    repeat (3) @(negedge clk);
    chk("busy_ready", 32'(ready), 32'd0);
    prev = bcd_out;
    issue(5555, 4'b1111);
    chk("busy_hold", 32'(bcd_out), 32'(prev));
    drain();

    for (int i = 0; i < 30; i++) begin
      issue(int'($urandom_range(0, 16383)), 4'($urandom));
      if ($urandom_range(0, 1) == 1) drain();
      else begin
        n = 0;
        while (!ready && n < 30) begin
          @(negedge clk);
          n++;
        end
      end
    end
    drain();

    issue(5678, 4'b0110);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    q.delete();
    chk("midrst_bcd", 32'(bcd_out), 32'hFFFF);
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_dp", 32'(dp_out), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    bin_in   = W'(100);
    dp_in    = 4'b0001;
    valid_in = 1'b1;
    reset    = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    valid_in = 1'b0;
    chk("rstvld_ready0", 32'(ready), 32'd1);
    @(negedge clk);
    chk("rstvld_ready1", 32'(ready), 32'd1);
    repeat (20) @(negedge clk);
    chk("rstvld_bcd", 32'(bcd_out), 32'hFFFF);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
